// File: rtl/vram_arbiter.sv
// vram_arbiter: two-master pipelined Wishbone arbiter (m0 priority) with outstanding tracking and ack watchdog
module vram_arbiter #(
    parameter int AW      = 32,
    parameter int OW      = 6,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_stall_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_stall_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_stall_i,
    output logic [1:0]    gnt_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] outstanding;
    logic [TW-1:0] timer;
    logic          busy, full, timeout, inc, dec, own1;

    assign busy     = outstanding != '0;
    assign full     = outstanding == '1;
    assign timeout  = timer == TW'(TIMEOUT);
    assign own1     = state == GNT1;
    assign inc      = s_stb_o & ~s_stall_i;
    assign dec      = s_ack_i & busy;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // state register; reset aborts any cycle in flight without draining
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // outstanding counter and watchdog; a timeout forgets every pending transfer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding <= '0;
            timer       <= '0;
        end else if (timeout) begin
            outstanding <= '0;
            timer       <= '0;
        end else begin
            outstanding <= outstanding + OW'(inc) - OW'(dec);
            timer       <= (busy && !s_ack_i) ? timer + 1'b1 : '0;
        end
    end

    // next state and bus routing, all decoded from the registered state
    always_comb begin
        state_nxt  = state;
        gnt_o      = 2'b00;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = own1 ? m1_we_i  : m0_we_i;
        s_sel_o    = own1 ? m1_sel_i : m0_sel_i;
        s_adr_o    = own1 ? m1_adr_i : m0_adr_i;
        s_dat_o    = own1 ? m1_dat_i : m0_dat_i;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_err_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        case (state)
            IDLE: state_nxt = m0_cyc_i ? GNT0 : (m1_cyc_i ? GNT1 : IDLE);
            GNT0: begin
                gnt_o      = 2'b01;
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_cyc_i & m0_stb_i & ~full;
                m0_stall_o = s_stall_i | full;
                m0_ack_o   = dec;
                m0_err_o   = timeout;
                if (!m0_cyc_i) state_nxt = busy ? DRAIN : IDLE;
            end
            GNT1: begin
                gnt_o      = 2'b10;
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_cyc_i & m1_stb_i & ~full;
                m1_stall_o = s_stall_i | full;
                m1_ack_o   = dec;
                m1_err_o   = timeout;
                if (!m1_cyc_i) state_nxt = busy ? DRAIN : IDLE;
            end
            DRAIN: begin
                s_cyc_o = 1'b1;
                if (!busy || timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Two-master, one-slave pipelined Wishbone arbiter in front of the video RAM port, on clk_i.
- Master 0 is the text display row fetcher and has absolute priority. Master 1 is the CPU.
- Grants are held for a whole bus cycle (cyc). Outstanding reads are tracked so a master that abandons its cycle cannot leak stray acks to the next owner.
- A watchdog returns err to the owner if the slave stops acking.

Parameters:
- AW, 32, address width of all ports.
- OW, 6, width of the outstanding-transfer counter; maximum outstanding is 2^OW-1.
- TIMEOUT, 255, cycles without an ack, while transfers are outstanding, before an error is raised.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  display master controls.
- m0_sel_i  in  4  byte selects.
- m0_adr_i  in  AW  address.
- m0_dat_i  in  32  write data.
- m0_dat_o  out  32  read data.
- m0_ack_o, m0_stall_o, m0_err_o  out  1 each  responses.
- m1_*  same set as m0_*  CPU master.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls.
- s_sel_o  out  4  byte selects.
- s_adr_o  out  AW  address.
- s_dat_o  out  32  write data.
- s_dat_i  in  32  read data.
- s_ack_i, s_stall_i  in  1 each  slave responses.
- gnt_o  out  2  one-hot current owner; 0 when idle or draining.

Behaviour:
- Clocking and reset:
  - Single clock clk_i.
  - rst_i is asynchronous and active-high.
  - During reset: state=IDLE, outstanding=0, timer=0.
  - Output values under reset: s_cyc_o=0, s_stb_o=0, gnt_o=0, all m*_ack_o=0, all m*_err_o=0, all m*_stall_o=1.
  - Assertion mid-cycle aborts immediately; no drain is performed.
- States are IDLE, GNT0, GNT1 and DRAIN. All outputs are decoded combinationally from the registered state.
- IDLE:
  - m0_cyc_i=1 -> GNT0; otherwise m1_cyc_i=1 -> GNT1.
  - Simultaneous requests go to m0.
  - Arbitration latency: a request sampled at edge n gives s_cyc_o=1 in cycle n+1.
- GNTx, owner x:
  - s_cyc/stb/we/sel/adr/dat_o = mx inputs.
  - s_stb_o is forced 0 while outstanding = 2^OW-1.
  - mx_stall_o = s_stall_i OR counter-full.
  - mx_ack_o = s_ack_i AND outstanding>0.
  - The non-owner sees stall=1, ack=0, err=0.
  - Both m*_dat_o = s_dat_i.
- Owner drops cyc:
  - outstanding=0 -> IDLE.
  - Otherwise -> DRAIN.
  - There is no direct GNT1->GNT0 handover; every transition passes through IDLE, costing 1 dead cycle.
- DRAIN:
  - s_cyc_o=1, s_stb_o=0.
  - Acks are absorbed and not forwarded.
  - outstanding=0 or timer=TIMEOUT -> IDLE.
- Outstanding counter update per cycle:
  - +1 on s_stb_o & ~s_stall_i.
  - -1 on a forwarded or absorbed ack.
  - Both in the same cycle -> unchanged.
  - An ack arriving when the counter is 0 is dropped; the counter stays 0.
- Watchdog timer:
  - Increments each cycle with outstanding>0 and no ack.
  - Clears on any ack or when outstanding=0.
  - On reaching TIMEOUT in GNTx: owner err_o pulses high for exactly 1 cycle, outstanding is cleared, timer is cleared, and the state remains GNTx.
- m1 is never preempted mid-cycle. m0 waits at most until m1 drops cyc plus any drain time.
- No write buffering. All paths are combinational through the arbiter; register delay is 0 once granted.

Test Plan:
- m0 and m1 both assert cyc at edge 0 -> gnt_o=01 at cycle 1. m0 issues 40 stb, slave acks each 2 cycles later -> 40 m0 acks, 0 m1 acks, m1_stall_o=1 throughout. m0 drops cyc -> IDLE for 1 cycle, then gnt_o=10.
- m1 owns the bus and m0 raises cyc mid-burst -> m1 keeps the grant until its cyc drops. gnt_o goes 10->00->01 with exactly one idle cycle.
- m0 issues 5 reads, drops cyc after 2 acks -> DRAIN. The remaining 3 acks are absorbed, with m0_ack_o=0 and m1_ack_o=0. IDLE follows the 3rd ack; m1 is granted the next cycle.
- TIMEOUT=8, slave never acks 1 outstanding read -> m1_err_o high for exactly 1 cycle, 9 cycles after the stb; outstanding returns to 0; grant kept.
- OW=2, slave stalls acks -> after 3 accepted stb, s_stb_o=0 and m0_stall_o=1. One ack releases one more stb.
- rst_i asserted asynchronously mid-burst in GNT0 -> s_cyc_o=0 and gnt_o=0 before the next edge. After release with m1_cyc_i=1 -> gnt_o=10 one cycle later; a stray s_ack_i is not forwarded.
